ahb_bram_ctrl: RTL and testbench

//  AHB-Lite slave that drives the dual-port Block_RAM (write port a, registered read port b) as the M0 code/data memory.

---
 rtl/ahb_bram_ctrl.sv | 157 +++++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave front-end for a dual-port Block_RAM (port a write, port b registered read).
// Zero-wait aligned accesses, write-to-read byte forwarding, two-cycle ERROR for illegal transfers.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [3:0]            ram_wea,
    output logic [31:0]           ram_dina,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    wr_pend_q, wr_pend_d;
    logic                    rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              be_q, be_d;
    logic                    fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0]   fwd_addr_q, fwd_addr_d;
    logic [3:0]              fwd_be_q, fwd_be_d;
    logic [31:0]             fwd_data_q, fwd_data_d;

    logic                    accept;
    logic                    legal;
    logic [3:0]              be;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    fwd_hit;
    logic [31:0]             rd_merged;

    // Aliased upper address bits and HTRANS[0] (NONSEQ vs SEQ) carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign accept    = HSEL & HTRANS[1] & HREADY;
    assign word_addr = HADDR[ADDR_WIDTH+1:2];

    always_comb begin
        legal = 1'b0;
        be    = 4'b0000;
        case (HSIZE)
            3'd0: begin
                legal = 1'b1;
                be    = 4'b0001 << HADDR[1:0];
            end
            3'd1: begin
                legal = ~HADDR[0];
                be    = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                legal = (HADDR[1:0] == 2'b00);
                be    = 4'b1111;
            end
            default: begin
                legal = 1'b0;
                be    = 4'b0000;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OKAY: if (accept && !legal) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = (accept && !legal) ? ST_ERR1 : ST_OKAY;
            default: state_d = ST_OKAY;
        endcase
    end

    // Phase registers only advance when the bus completes a cycle.
    always_comb begin
        wr_pend_d   = wr_pend_q;
        rd_pend_d   = rd_pend_q;
        addr_d      = addr_q;
        be_d        = be_q;
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_be_d    = fwd_be_q;
        fwd_data_d  = fwd_data_q;
        if (HREADY) begin
            wr_pend_d   = accept & legal & HWRITE;
            rd_pend_d   = accept & legal & ~HWRITE;
            if (accept && legal) begin
                addr_d = word_addr;
                be_d   = be;
            end
            fwd_valid_d = wr_pend_q;
            if (wr_pend_q) begin
                fwd_addr_d = addr_q;
                fwd_be_d   = be_q;
                fwd_data_d = HWDATA;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_OKAY;
            wr_pend_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_be_q    <= 4'b0000;
            fwd_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            wr_pend_q   <= wr_pend_d;
            rd_pend_q   <= rd_pend_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_be_q    <= fwd_be_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    // The read-first RAM returns pre-write data when a read address phase overlapped the
    // previous write's data phase; patch the written bytes from the forwarding register.
    assign fwd_hit = fwd_valid_q && (addr_q == fwd_addr_q);

    always_comb begin
        rd_merged = ram_doutb;
        for (int i = 0; i < 4; i++) begin
            if (fwd_hit && fwd_be_q[i]) rd_merged[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
    end

    assign HREADYOUT = (state_q != ST_ERR1);
    assign HRESP     = (state_q != ST_OKAY);
    assign HRDATA    = rd_pend_q ? rd_merged : 32'h0;
    assign ram_addra = addr_q;
    assign ram_wea   = wr_pend_q ? be_q : 4'b0000;
    assign ram_dina  = HWDATA;
    assign ram_addrb = word_addr;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed + randomized bench for ahb_bram_ctrl against a transaction-level memory model.
module tb_ahb_bram_ctrl;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          HSEL = 1'b0;
    logic [31:0]   HADDR = 32'h0;
    logic [1:0]    HTRANS = 2'b00;
    logic [2:0]    HSIZE = 3'd0;
    logic          HWRITE = 1'b0;
    logic [31:0]   HWDATA = 32'h0;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] ram_addra;
    logic [3:0]    ram_wea;
    logic [31:0]   ram_dina;
    logic [AW-1:0] ram_addrb;
    logic [31:0]   ram_doutb = 32'h0;

    logic          force_low = 1'b0;
    logic          ram_init = 1'b1;
    logic [31:0]   mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    logic [31:0]   ref_mem [DEPTH];
    bit            pw = 1'b0, pr = 1'b0;
    int            pword = 0;
    logic [3:0]    pbe = 4'h0;
    logic [31:0]   pwdata = 32'h0, prexp = 32'h0;
    int            err = 0;

    always #5 HCLK = ~HCLK;
    assign HREADY = force_low ? 1'b0 : HREADYOUT;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .ram_addra(ram_addra), .ram_wea(ram_wea), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    function automatic logic [31:0] init_word(int i);
        return ((32'(i) + 32'd1) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Read-first Block_RAM with byte enables on port a
    always @(posedge HCLK) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
        end
        ram_doutb <= mem[ram_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit is_legal(logic [2:0] size, logic [31:0] a);
        return (size <= 3'd2) && ((a % (32'd1 << size)) == 0);
    endfunction

    function automatic logic [3:0] lanes(logic [2:0] size, logic [31:0] a);
        if (size == 3'd0) return 4'(1 << (a % 4));
        if (size == 3'd1) return 4'(3 << (a % 4));
        return 4'hF;
    endfunction

    // One bus cycle: drive address phase (and pending write data), check the pending
    // data phase at the falling edge, then advance the model at the rising edge.
    task automatic cyc(input bit sel, input logic [1:0] trans, input bit wr,
                       input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hlow);
        bit hr;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
        HWDATA = pwdata; force_low = hlow;
        @(negedge HCLK);
        chk("hreadyout", 32'(HREADYOUT), (err == 2) ? 32'd0 : 32'd1);
        chk("hresp", 32'(HRESP), (err != 0) ? 32'd1 : 32'd0);
        chk("wea", 32'(ram_wea), pw ? 32'(pbe) : 32'd0);
        if (pw) begin
            chk("addra", 32'(ram_addra), 32'(pword));
            chk("dina", ram_dina, pwdata);
        end
        chk("hrdata", HRDATA, pr ? prexp : 32'h0);
        chk("addrb", 32'(ram_addrb), 32'(word_of(addr)));
        @(posedge HCLK);
        hr = !hlow && (err != 2);
        if (err > 0) err--;
        if (hr) begin
            if (pw)
                for (int b = 0; b < 4; b++)
                    if (pbe[b]) ref_mem[pword][8*b +: 8] = pwdata[8*b +: 8];
            pw = 1'b0; pr = 1'b0;
            if (sel && trans[1]) begin
                if (is_legal(size, addr)) begin
                    pw = wr; pr = !wr;
                    pword = word_of(addr);
                    pbe = lanes(size, addr);
                    pwdata = wdata;
                    if (!wr) prexp = ref_mem[pword];
                end else begin
                    err = 2;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (2) @(posedge HCLK);
        #1 ram_init = 1'b0;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_wea", 32'(ram_wea), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // T1: aliased word write then read
        cyc(1, 2'b10, 1, 3'd2, 32'h2000_0010, 32'hDEADBEEF, 0);
        chk("t1_wea", 32'(ram_wea), 32'hF);
        chk("t1_addra", 32'(ram_addra), 32'd4);
        cyc(1, 2'b10, 0, 3'd2, 32'h2000_0010, 32'h0, 0);
        chk("t1_rd", HRDATA, 32'hDEADBEEF);
        idle();

        // T2: byte merges into 0xAABBCCDD
        cyc(1, 2'b10, 1, 3'd2, 32'h0, 32'hAABBCCDD, 0);
        cyc(1, 2'b10, 1, 3'd0, 32'h0, 32'h0000_0011, 0);
        cyc(1, 2'b11, 1, 3'd0, 32'h3, 32'h2200_0000, 0);
        chk("t2_wea", 32'(ram_wea), 32'h8);
        idle();
        cyc(1, 2'b10, 0, 3'd2, 32'h0, 32'h0, 0);
        chk("t2_rd", HRDATA, 32'h22BBCC11);
        idle();

        // T3: read in the write's data phase relies on forwarding
        cyc(1, 2'b10, 1, 3'd2, 32'h40, 32'h12345678, 0);
        cyc(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 0);
        chk("t3_fwd", HRDATA, 32'h12345678);
        idle();

        // T4: misaligned halfword write -> ERROR, memory unchanged
        cyc(1, 2'b10, 1, 3'd1, 32'h41, 32'hFFFF_FFFF, 0);
        chk("t4_err1", {30'd0, HREADYOUT, HRESP}, 32'h1);
        idle();
        chk("t4_err2", {30'd0, HREADYOUT, HRESP}, 32'h3);
        cyc(1, 2'b10, 0, 3'd2, 32'h40, 32'h0, 0);
        chk("t4_rd", HRDATA, 32'h12345678);
        idle();

        // T5: oversize read then legal read issued in ERR2
        cyc(1, 2'b10, 0, 3'd3, 32'h0, 32'h0, 0);
        idle();
        cyc(1, 2'b10, 0, 3'd2, 32'h10, 32'h0, 0);
        chk("t5_rd", HRDATA, 32'hDEADBEEF);
        chk("t5_resp", 32'(HRESP), 32'd0);
        idle();

        // T6: reset during a write data phase
        cyc(1, 2'b10, 1, 3'd2, 32'h80, 32'hCAFEF00D, 0);
        HSEL = 1'b0; HTRANS = 2'b00; HRESETn = 1'b0;
        #2;
        chk("t6_wea", 32'(ram_wea), 32'd0);
        chk("t6_ready", {30'd0, HREADYOUT, HRESP}, 32'h2);
        pw = 1'b0; pr = 1'b0; err = 0;
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;
        cyc(1, 2'b10, 0, 3'd2, 32'h80, 32'h0, 0);
        chk("t6_rd", HRDATA, init_word(32));
        idle();

        // HREADY held low, HSEL low, BUSY: none may reach the RAM
        cyc(1, 2'b10, 1, 3'd2, 32'h84, 32'h1111_1111, 1);
        cyc(0, 2'b10, 1, 3'd2, 32'h88, 32'h2222_2222, 0);
        cyc(1, 2'b01, 1, 3'd2, 32'h8C, 32'h3333_3333, 0);
        idle();
        chk("noacc_wea", 32'(ram_wea), 32'd0);

        // Randomized traffic over a handful of aliased words
        for (int n = 0; n < 600; n++) begin
            sz = ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'(3 + $urandom % 5);
            a = ($urandom & 32'hFFFF_FC00) | (($urandom % 8) << 2);
            if ($urandom % 4 == 0) a = a | ($urandom % 4);
            else if (sz == 3'd0) a = a | ($urandom % 4);
            else if (sz == 3'd1) a = a | (($urandom % 2) << 1);
            cyc(($urandom % 8) != 0, 2'($urandom % 4), 1'($urandom % 2), sz, a, $urandom,
                (!pw && !pr && err == 0 && ($urandom % 10 == 0)));
        end
        repeat (4) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
